// File: rtl/req_encoder8.sv
// Registered 8-to-3 request encoder with valid/ready offer, round-robin or
// fixed-priority arbitration, and a wrapping accepted-grant counter.
module req_encoder8 #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  input  logic             enc_ready,
  output logic             enc_valid,
  output logic [2:0]       enc_idx,
  output logic [7:0]       enc_onehot,
  output logic             enc_multi,
  output logic [CNT_W-1:0] gnt_cnt
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  localparam bit RR_ON = (RR_EN != 0);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ptr;
  logic [2:0] start;
  logic [2:0] pick;
  logic       multi_nxt;
  logic       load;
  logic       accept;

  // First set bit of r at or after index s, searching upward with wrap 7->0.
  function automatic logic [2:0] sel_first(input logic [7:0] r, input logic [2:0] s);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    dbl = {r, r} >> s;
    rot = dbl[7:0];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        off = 3'(i);
      end else begin
        off = off;
      end
    end
    return s + off;
  endfunction

  function automatic logic many(input logic [7:0] r);
    return (r & (r - 8'd1)) != 8'd0;
  endfunction

  assign enc_valid = (state == OFFER);

  // Next-state, accept and selection-start decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    start     = 3'd0;
    case (state)
      IDLE: begin
        start = RR_ON ? ptr : 3'd0;
        if (req != 8'd0) begin
          state_nxt = OFFER;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      OFFER: begin
        accept = enc_ready;
        start  = RR_ON ? (enc_idx + 3'd1) : 3'd0;
        if (enc_ready) begin
          if (req != 8'd0) begin
            state_nxt = OFFER;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = OFFER;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    pick      = sel_first(req, start);
    multi_nxt = many(req);
  end

  // State, pointer, offer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      enc_idx    <= 3'd0;
      enc_onehot <= 8'd0;
      enc_multi  <= 1'b0;
      gnt_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt_cnt <= gnt_cnt + CNT_W'(1);
        ptr     <= enc_idx + 3'd1;
      end else begin
        gnt_cnt <= gnt_cnt;
        ptr     <= ptr;
      end
      if (load) begin
        enc_idx    <= pick;
        enc_onehot <= 8'd1 << pick;
        enc_multi  <= multi_nxt;
      end else if (state_nxt == IDLE) begin
        // enc_idx keeps its last value while invalid.
        enc_onehot <= 8'd0;
        enc_multi  <= 1'b0;
      end else begin
        enc_onehot <= enc_onehot;
        enc_multi  <= enc_multi;
      end
    end
  end

endmodule

// File: tb/tb_req_encoder8.sv
// Bench for req_encoder8: three instances (round-robin, fixed priority, 2-bit
// counter) share stimulus; a behavioural model checks all of them every cycle.
module tb_req_encoder8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       enc_ready = 1'b0;
  logic       chk_en = 1'b0;

  logic       v  [3];
  logic [2:0] ix [3];
  logic [7:0] oh [3];
  logic       mu [3];
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  req_encoder8 #(.RR_EN(1), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst), .req(req), .enc_ready(enc_ready),
    .enc_valid(v[0]), .enc_idx(ix[0]), .enc_onehot(oh[0]), .enc_multi(mu[0]), .gnt_cnt(cnt0));
  req_encoder8 #(.RR_EN(0), .CNT_W(8)) u_fx (
    .clk(clk), .rst(rst), .req(req), .enc_ready(enc_ready),
    .enc_valid(v[1]), .enc_idx(ix[1]), .enc_onehot(oh[1]), .enc_multi(mu[1]), .gnt_cnt(cnt1));
  req_encoder8 #(.RR_EN(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .req(req), .enc_ready(enc_ready),
    .enc_valid(v[2]), .enc_idx(ix[2]), .enc_onehot(oh[2]), .enc_multi(mu[2]), .gnt_cnt(cnt2));

  // Behavioural model: one entry per instance.
  int m_valid [3];
  int m_idx   [3];
  int m_multi [3];
  int m_cnt   [3];
  int m_ptr   [3];
  int rr_mode [3] = '{1, 0, 1};
  int cnt_mod [3] = '{256, 256, 4};

  function automatic int msel(input logic [7:0] r, input int s);
    for (int k = 0; k < 8; k++) begin
      if (r[(s + k) % 8]) return (s + k) % 8;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        m_valid[m] <= 0; m_idx[m] <= 0; m_multi[m] <= 0; m_cnt[m] <= 0; m_ptr[m] <= 0;
      end else if (m_valid[m] != 0) begin
        if (enc_ready) begin
          m_cnt[m] <= (m_cnt[m] + 1) % cnt_mod[m];
          m_ptr[m] <= (m_idx[m] + 1) % 8;
          if (req != 8'h00) begin
            m_idx[m]   <= msel(req, (rr_mode[m] != 0) ? (m_idx[m] + 1) % 8 : 0);
            m_multi[m] <= ($countones(req) > 1) ? 1 : 0;
          end else begin
            m_valid[m] <= 0;
          end
        end
      end else if (req != 8'h00) begin
        m_valid[m] <= 1;
        m_idx[m]   <= msel(req, (rr_mode[m] != 0) ? m_ptr[m] : 0);
        m_multi[m] <= ($countones(req) > 1) ? 1 : 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int m);
    if (m == 0) return int'(cnt0);
    if (m == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  // Compare DUTs against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 3; m++) begin
        check($sformatf("valid%0d", m), int'(v[m]), m_valid[m]);
        check($sformatf("onehot%0d", m), int'(oh[m]), (m_valid[m] != 0) ? (1 << m_idx[m]) : 0);
        check($sformatf("cnt%0d", m), cnt_of(m), m_cnt[m]);
        if (m_valid[m] != 0) begin
          check($sformatf("idx%0d", m), int'(ix[m]), m_idx[m]);
          check($sformatf("multi%0d", m), int'(mu[m]), m_multi[m]);
        end
      end
    end
  end

  task automatic cyc(input logic [7:0] r, input logic rdy);
    req = r;
    enc_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  int exp_rr [4] = '{0, 6, 0, 6};
  int exp_c2 [5] = '{1, 2, 3, 0, 1};

  initial begin
    // Reset with all requests asserted.
    rst = 1'b1;
    cyc(8'hFF, 1'b0);
    chk_en = 1'b1;
    cyc(8'hFF, 1'b0);
    check("rst_valid", int'(v[0]), 0);
    check("rst_onehot", int'(oh[0]), 0);
    check("rst_idx", int'(ix[0]), 0);
    check("rst_multi", int'(mu[0]), 0);
    check("rst_cnt", int'(cnt0), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(8'h00, 1'b1);
    check("idle_valid", int'(v[0]), 0);
    check("idle_cnt", int'(cnt0), 0);

    // One-clock latency, then hold for four cycles with ready low.
    cyc(8'h10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", int'(v[0]), 1);
      check("hold_idx", int'(ix[0]), 4);
      check("hold_onehot", int'(oh[0]), 8'h10);
      check("hold_multi", int'(mu[0]), 0);
      cyc((i == 1) ? 8'hFF : 8'h00, 1'b0);
    end
    cyc(8'h00, 1'b1);
    check("acc_cnt", int'(cnt0), 1);
    check("acc_valid", int'(v[0]), 0);

    // Round-robin wrap and fixed priority on req=0x41.
    rst = 1'b1;
    cyc(8'h00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(8'h41, 1'b1);
      check("rr_idx", int'(ix[0]), exp_rr[i]);
      check("rr_valid", int'(v[0]), 1);
      check("rr_multi", int'(mu[0]), 1);
      check("fx_idx", int'(ix[1]), 0);
      check("fx_onehot", int'(oh[1]), 8'h01);
    end
    cyc(8'h00, 1'b1);
    cyc(8'h41, 1'b0);
    check("rr_ptr7_idx", int'(ix[0]), 0);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);

    // Two-bit counter wrap.
    rst = 1'b1;
    cyc(8'h00, 1'b0);
    rst = 1'b0;
    cyc(8'h80, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(8'h80, 1'b1);
      check("c2_cnt", int'(cnt2), exp_c2[i]);
    end
    cyc(8'h00, 1'b1);

    // Reset in the same edge as an accept.
    rst = 1'b1;
    cyc(8'h00, 1'b0);
    rst = 1'b0;
    cyc(8'h08, 1'b0);
    check("mid_idx", int'(ix[0]), 3);
    rst = 1'b1;
    cyc(8'h08, 1'b1);
    check("mid_valid", int'(v[0]), 0);
    check("mid_cnt", int'(cnt0), 0);
    rst = 1'b0;
    cyc(8'h88, 1'b0);
    check("mid_next_idx", int'(ix[0]), 3);
    check("mid_next_multi", int'(mu[0]), 1);
    cyc(8'hC0, 1'b1);
    check("rr_after3", int'(ix[0]), 6);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
